// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: DATA_W-bit words in, BPC bits folded per clock,
// finalised CRC presented on a held result handshake.
module crc_stream_engine #(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT = 16'h0000,
  parameter int               DATA_W = 8,
  parameter int               BPC    = 1,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CRC_W-1:0]  res_crc
);

  localparam int N     = DATA_W / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  crc_step;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_w;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_end;
  logic              fb;

  function automatic logic [DATA_W-1:0] rev_word(
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] o;
    for (int i = 0; i < DATA_W; i++) o[i] = x[DATA_W-1-i];
    return o;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(
    input logic [CRC_W-1:0] x
  );
    logic [CRC_W-1:0] o;
    for (int i = 0; i < CRC_W; i++) o[i] = x[CRC_W-1-i];
    return o;
  endfunction

  assign cnt_end = (cnt_q == CNT_W'(N - 1));
  assign crc_out = crc_q;
  assign res_crc = (REFOUT ? rev_crc(crc_q) : crc_q) ^ XOROUT;

  // BPC single-bit steps chained within one cycle, word MSB first
  always_comb begin
    crc_step = crc_q;
    word_w   = word_q;
    fb       = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      fb       = crc_step[CRC_W-1] ^ word_w[DATA_W-1];
      crc_step = {crc_step[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      word_w   = word_w << 1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; init aborts everything
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt_end) state_nxt = last_q ? DONE : IDLE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (init) state_nxt = IDLE;
  end

  // Datapath: word capture, CRC folding, counter, return to INIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q  <= INIT;
      word_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else if (init) begin
      crc_q  <= INIT;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= REFIN ? rev_word(in_data) : in_data;
            last_q <= in_last;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          crc_q  <= crc_step;
          word_q <= word_w;
          cnt_q  <= cnt_q + 1'b1;
        end
        DONE: begin
          if (res_ready) crc_q <= INIT;
        end
        default: ;
      endcase
    end
  end

endmodule
